// File: rtl/mscan_n1e_if.sv
// rtl/mscan_n1e_if.sv - capture controls, channel data and output handshake bundle for mscan_n1e
//
// Purpose : groups every non-clock, non-reset signal of the mscan_n1e
//           channel scanner so that producer and consumer connect through
//           a single port.
// Signals : CE     capture clock enable
//           E      data enable (0 captures an all-zero word)
//           MODE   0 = direct select, 1 = masked round-robin scan
//           S      direct-mode channel select
//           MASK   scan-mode channel enables, bit i enables channel i
//           D      packed channel data, channel i at D[i*W +: W]
//           O      registered output word
//           O_VLD  O holds a word not yet accepted
//           O_RDY  downstream accept
//           CH     channel index that produced O
//           WRAP   marks the first word of a scan round
// Modports: master drives the controls and data and accepts the output;
//           slave is the scanner itself.

interface mscan_n1e_if #(
   parameter int W  = 16,
   parameter int N  = 8,
   parameter int SW = 3
);
   logic          CE;
   logic          E;
   logic          MODE;
   logic [SW-1:0] S;
   logic [N-1:0]  MASK;
   logic [N*W-1:0] D;
   logic [W-1:0]  O;
   logic          O_VLD;
   logic          O_RDY;
   logic [SW-1:0] CH;
   logic          WRAP;

   modport master (
      output CE, E, MODE, S, MASK, D, O_RDY,
      input  O, O_VLD, CH, WRAP
   );

   modport slave (
      input  CE, E, MODE, S, MASK, D, O_RDY,
      output O, O_VLD, CH, WRAP
   );
endinterface

// File: rtl/mscan_n1e.sv
// rtl/mscan_n1e.sv - N-channel capture mux with direct select and masked round-robin scan
//
// Purpose : each accepted cycle captures one channel word from D into a
//           registered output with a valid/ready handshake. In direct mode
//           the channel is S; in scan mode the enabled channels of MASK are
//           visited round-robin starting from an internal pointer.
// Ports   : C    clock, rising edge
//           CLR  asynchronous active-high reset
//           bus  mscan_n1e_if slave modport (controls, data, output handshake)
// Params  : W data width per channel, N channel count, SW = ceil(log2(N)).

module mscan_n1e #(
   parameter int W  = 16,
   parameter int N  = 8,
   parameter int SW = 3
) (
   input logic        C,
   input logic        CLR,
   mscan_n1e_if.slave bus
);

   // registered state
   logic [W-1:0]  o_q,         o_d;
   logic          o_vld_q,     o_vld_d;
   logic [SW-1:0] ch_q,        ch_d;
   logic          wrap_q,      wrap_d;
   logic [SW-1:0] ptr_q,       ptr_d;
   logic [SW-1:0] last_q,      last_d;
   logic          first_q,     first_d;
   logic          mode_prev_q, mode_prev_d;

   // combinational helpers
   logic [W-1:0]  ch_word [N];
   logic          mode_chg;
   logic [SW-1:0] start;
   logic          scan_found;
   logic [SW-1:0] scan_idx;
   logic [SW-1:0] pos;
   logic [SW-1:0] chosen;
   logic [W-1:0]  word;
   logic          load;
   logic          first_eff;

   // unpack the channel bus into one word per channel
   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign ch_word[g] = bus.D[g*W +: W];
   end

   // round-robin search over MASK starting at the effective pointer
   always_comb begin
      mode_chg   = bus.MODE ^ mode_prev_q;
      // a mode change restarts the search at channel 0 in the same cycle
      start      = mode_chg ? '0 : ptr_q;
      scan_found = 1'b0;
      scan_idx   = '0;
      pos        = '0;
      for (int k = 0; k < N; k++) begin
         pos = SW'((int'(start) + k) % N);
         if (!scan_found && bus.MASK[pos]) begin
            scan_found = 1'b1;
            scan_idx   = pos;
         end
      end
   end

   // channel choice and captured word
   always_comb begin
      word   = '0;
      chosen = bus.S;
      if (bus.MODE) begin
         chosen = scan_idx;
         word   = ch_word[scan_idx];
      end else if (int'(bus.S) < N) begin
         word = ch_word[bus.S];
      end
      // out-of-range direct selects keep the zero word but still report S
      if (!bus.E) begin
         word = '0;
      end
   end

   // an empty mask in scan mode has nothing to capture, so no load
   assign load      = bus.CE && (!o_vld_q || bus.O_RDY) && (!bus.MODE || (|bus.MASK));
   assign first_eff = first_q | mode_chg;

   // next-state
   always_comb begin
      o_d         = o_q;
      o_vld_d     = o_vld_q;
      ch_d        = ch_q;
      wrap_d      = wrap_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      first_d     = first_q;
      mode_prev_d = bus.MODE;

      if (mode_chg) begin
         ptr_d   = '0;
         first_d = 1'b1;
      end

      if (load) begin
         o_d     = word;
         ch_d    = chosen;
         o_vld_d = 1'b1;
         // a new round starts when the search has come back round to or
         // before the last channel served
         wrap_d  = bus.MODE && (first_eff || (scan_idx <= last_q));
         if (bus.MODE) begin
            ptr_d   = (int'(scan_idx) == N - 1) ? '0 : scan_idx + SW'(1);
            last_d  = scan_idx;
            first_d = 1'b0;
         end
      end else if (o_vld_q && bus.O_RDY) begin
         o_vld_d = 1'b0;
      end
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         o_q         <= '0;
         o_vld_q     <= 1'b0;
         ch_q        <= '0;
         wrap_q      <= 1'b0;
         ptr_q       <= '0;
         last_q      <= '0;
         first_q     <= 1'b1;
         mode_prev_q <= 1'b0;
      end else begin
         o_q         <= o_d;
         o_vld_q     <= o_vld_d;
         ch_q        <= ch_d;
         wrap_q      <= wrap_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         first_q     <= first_d;
         mode_prev_q <= mode_prev_d;
      end
   end

   assign bus.O     = o_q;
   assign bus.O_VLD = o_vld_q;
   assign bus.CH    = ch_q;
   assign bus.WRAP  = wrap_q;

endmodule

// File: doc/mscan_n1e.md
MSCAN_N1E -- requirements
Module: mscan_n1e

Interface
REQ-001 Parameter W, default 16, data width per channel (1..64).
REQ-002 Parameter N, default 8, channel count (2..16).
REQ-003 Parameter SW, default 3, select/index width; SHALL equal ceil(log2(N)).
REQ-004 C  input  1  clock; all state updates on rising edge.
REQ-005 CLR  input  1  reset, asynchronous, active-high.
REQ-006 CE  input  1  clock enable for capture.
REQ-007 E  input  1  data enable; 0 forces captured word to zero.
REQ-008 MODE  input  1  0 = direct select, 1 = masked round-robin scan.
REQ-009 S  input  SW  channel select, used in direct mode only.
REQ-010 MASK  input  N  scan-mode channel enables; bit i enables channel i.
REQ-011 D  input  N*W  channel data; channel i occupies D[i*W+W-1 : i*W].
REQ-012 O  output  W  registered output word.
REQ-013 O_VLD  output  1  O holds a word not yet accepted.
REQ-014 O_RDY  input  1  downstream accept; transfer when O_VLD and O_RDY both high.
REQ-015 CH  output  SW  channel index that produced O.
REQ-016 WRAP  output  1  registered with O; marks start of a scan round.

Function
REQ-017 LOAD SHALL be: CE and (not O_VLD or O_RDY) and (MODE=0 or MASK has at least one bit set).
REQ-018 On LOAD, O, CH, WRAP SHALL update at the next edge and O_VLD SHALL become 1; latency from D/S/MASK to O is one cycle.
REQ-019 Direct mode: the chosen index SHALL be S; if S >= N, O SHALL load 0 and CH SHALL load S.
REQ-020 Scan mode: the chosen index SHALL be the first i with MASK[i]=1, searching PTR, PTR+1, ... N-1, 0, ... PTR-1.
REQ-021 Scan mode on LOAD: PTR SHALL become (chosen+1) mod N; wraps from N-1 to 0.
REQ-022 Direct mode: PTR SHALL NOT change.
REQ-023 Captured word SHALL be D[chosen] when E=1, and all zeros when E=0; a zero word is still a valid transfer.
REQ-024 WRAP SHALL load 1 on a scan LOAD when FIRST=1 or chosen <= LAST; otherwise 0. WRAP SHALL load 0 on every direct LOAD.
REQ-025 On a scan LOAD, LAST SHALL become chosen and FIRST SHALL become 0.
REQ-026 Stall: when O_VLD=1 and O_RDY=0, O, CH, WRAP, O_VLD SHALL hold regardless of CE, S, MASK and D.
REQ-027 Drain: when O_VLD=1, O_RDY=1 and LOAD=0, O_VLD SHALL become 0; O, CH, WRAP hold their values.
REQ-028 Back-to-back: with O_RDY=1 and LOAD=1 every cycle, one word SHALL transfer per cycle with no bubble.
REQ-029 Mode change: a change of MODE relative to its value on the previous edge SHALL set PTR=0 and FIRST=1 at that edge. A LOAD in the same cycle SHALL use the post-change search start, PTR=0.
REQ-030 Scan mode with MASK=0: no LOAD; PTR, LAST and FIRST SHALL hold.
REQ-031 A MASK change between loads SHALL take effect on the next search; PTR SHALL NOT be reset by it.

Reset
REQ-032 CLR=1 SHALL immediately force O=0, O_VLD=0, CH=0, WRAP=0, PTR=0, LAST=0, FIRST=1, and the stored previous MODE=0, independent of C.
REQ-033 CLR asserted mid-stall or mid-scan SHALL discard the held word. After CLR falls, the first LOAD SHALL behave as a first capture.

Verification
REQ-034 Direct: N=8, W=16, MODE=0, E=1, CE=1, O_RDY=1, D[i]=16'h1110*i+i, S stepping 0..7 -> one cycle later O=D[S], CH=S, O_VLD=1, WRAP=0, one word per cycle.
REQ-035 Enable and out-of-range: E=0, S=5 -> O=16'h0000, O_VLD=1, CH=5. With N=6, S=7 -> O=0, CH=7.
REQ-036 Scan: MODE=1, MASK=8'b1010_0110, O_RDY=1 -> CH sequence 1,2,5,7,1,2...; WRAP=1 on the first 1 and on each later 1, else 0.
REQ-037 Backpressure: scan running, O_RDY=0 for 4 cycles -> O, CH, O_VLD=1 frozen; O_RDY back to 1 -> sequence resumes with no channel skipped or repeated.
REQ-038 Edge cases: MASK=0 with O_RDY=1 -> O_VLD falls after the held word drains, PTR holds. Toggling MODE 0->1 mid-run -> next CH is the lowest set MASK bit with WRAP=1.
REQ-039 Reset: CLR pulsed asynchronously (not aligned to C) during a stall -> O=0, O_VLD=0 without a clock edge. Then MODE=1, MASK=8'h80 -> first output CH=7, WRAP=1.
